// File: rtl/shift_seq.sv
// shift_seq: full-duplex serial engine that sequences an external multi-mode shift register
// through LOAD followed by WIDTH shifts per accepted word.
module shift_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    input  logic [WIDTH-1:0] tx_data_i,
    input  logic             dir_i,
    input  logic             pause_i,
    input  logic             sin_i,
    input  logic [WIDTH-1:0] sr_p_i,
    output logic [1:0]       sr_mode_o,
    output logic [WIDTH-1:0] sr_par_o,
    output logic             sr_d_o,
    output logic             sout_o,
    output logic             sout_valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] rx_data_o
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] data_q;
    logic             dir_q;
    logic [CW-1:0]    cnt;
    logic             shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            data_q    <= '0;
            dir_q     <= 1'b0;
            cnt       <= '0;
            rx_data_o <= '0;
        end else begin
            case (state)
                IDLE: if (tx_valid_i) begin
                    data_q <= tx_data_i;
                    dir_q  <= dir_i;
                    cnt    <= '0;
                    state  <= LOAD;
                end
                LOAD: state <= SHIFT;
                SHIFT: if (!pause_i) begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) state <= DONE;
                end
                DONE: begin
                    rx_data_o <= sr_p_i;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // a paused SHIFT cycle holds the register and does not advance the count
    assign shift        = (state == SHIFT) && !pause_i;
    assign sr_mode_o    = (state == LOAD) ? 2'b01 : shift ? {1'b1, dir_q} : 2'b00;
    assign sr_par_o     = data_q;
    assign sr_d_o       = sin_i;
    assign sout_o       = dir_q ? sr_p_i[0] : sr_p_i[WIDTH-1];
    assign sout_valid_o = shift;
    assign tx_ready_o   = (state == IDLE);
    assign busy_o       = (state != IDLE);
    assign done_o       = (state == DONE);
endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: drives shift_seq against a behavioural model of the attached shift register
// and checks serial streams, timing, pause, back-to-back handshakes and reset.
module tb_shift_seq;
    logic       clk = 1'b0;
    logic       rst, tx_valid, tx_ready, dir, pause, sin, sin_drv, loop_en;
    logic [7:0] tx_data, sr_p, sr_par, rx_data;
    logic [1:0] sr_mode;
    logic       sr_d, sout, sout_valid, busy, done;
    int         vec = 0, bad = 0;

    always #5 clk = ~clk;

    assign sin = loop_en ? sout : sin_drv;

    shift_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .tx_data_i(tx_data), .dir_i(dir), .pause_i(pause), .sin_i(sin),
        .sr_p_i(sr_p), .sr_mode_o(sr_mode), .sr_par_o(sr_par), .sr_d_o(sr_d),
        .sout_o(sout), .sout_valid_o(sout_valid), .busy_o(busy), .done_o(done),
        .rx_data_o(rx_data)
    );

    // the external HOLD/LOAD/LEFT/RIGHT register the sequencer controls
    initial sr_p = 8'h00;
    always @(posedge clk)
        case (sr_mode)
            2'b01:   sr_p <= sr_par;
            2'b10:   sr_p <= {sr_p[6:0], sr_d};
            2'b11:   sr_p <= {sr_d, sr_p[7:1]};
            default: sr_p <= sr_p;
        endcase

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // sin_kind: 0 const 0, 1 const 1, 2 random, 3 loopback
    task automatic xfer(input string tag, input logic [7:0] w, input logic d, input int sin_kind,
                        input int p_after, input int p_len);
        logic [7:0] got_s, exp_s, s_bits, exp_rx;
        int n, cyc, pcnt;
        bit seen;
        loop_en = (sin_kind == 3);
        @(negedge clk);
        tx_data = w; dir = d; tx_valid = 1'b1;
        #1 chk({tag, "_ready"}, tx_ready, 1);
        @(negedge clk);
        tx_valid = 1'b0; tx_data = $urandom; dir = $urandom;
        n = 0; cyc = 1; pcnt = 0; seen = 0; got_s = '0; s_bits = '0;
        while (!seen && cyc < 40) begin
            pause   = (n == p_after) && (pcnt < p_len);
            sin_drv = (sin_kind == 2) ? 1'($urandom) : (sin_kind == 1);
            #1;
            if (cyc == 1) begin
                chk({tag, "_load_mode"}, sr_mode, 2'b01);
                chk({tag, "_load_par"}, sr_par, w);
            end
            if (pause) begin
                chk({tag, "_pause_mode"}, sr_mode, 2'b00);
                chk({tag, "_pause_valid"}, sout_valid, 0);
                pcnt++;
            end
            if (sout_valid && n < 8) begin
                got_s[n]  = sout;
                s_bits[n] = sin;
                n++;
            end
            if (done) begin
                seen = 1;
                chk({tag, "_done_lat"}, cyc, 10 + p_len);
            end
            @(negedge clk);
            cyc++;
        end
        pause = 1'b0;
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_nbits"}, n, 8);
        for (int i = 0; i < 8; i++) begin
            exp_s[i]  = d ? w[i] : w[7-i];
            exp_rx[i] = d ? s_bits[i] : s_bits[7-i];
        end
        chk({tag, "_stream"}, got_s, exp_s);
        #1;
        chk({tag, "_rx"}, rx_data, exp_rx);
        chk({tag, "_p"}, sr_p, exp_rx);
        chk({tag, "_idle"}, {tx_ready, busy, done}, 3'b100);
        loop_en = 1'b0;
    endtask

    initial begin
        int hs[2];
        int k, cyc;
        rst = 1'b1; tx_valid = 1'b0; tx_data = '0; dir = 1'b0; pause = 1'b0;
        sin_drv = 1'b0; loop_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1;
        chk("rst_mode", sr_mode, 2'b00);
        chk("rst_outs", {tx_ready, busy, done, sout_valid}, 4'b1000);
        chk("rst_rx", rx_data, 8'h00);
        chk("rst_par", sr_par, 8'h00);

        // reset asserted during the 5th shift abandons the transfer
        @(negedge clk);
        tx_data = 8'h5C; dir = 1'b0; tx_valid = 1'b1; sin_drv = 1'b1;
        @(negedge clk) tx_valid = 1'b0;
        k = 0; cyc = 0;
        while (k < 5 && cyc < 20) begin
            #1 if (sout_valid) k++;
            if (k < 5) @(negedge clk);
            cyc++;
        end
        chk("rstmid_reached", k, 5);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        #1;
        chk("rstmid_mode", sr_mode, 2'b00);
        chk("rstmid_outs", {tx_ready, busy, done}, 3'b100);
        k = 0;
        repeat (12) begin
            @(negedge clk);
            #1 if (done || busy) k++;
        end
        chk("rstmid_quiet", k, 0);
        chk("rstmid_rx", rx_data, 8'h00);

        xfer("t1", 8'h1E, 1'b0, 0, -1, 0);
        chk("t1_rx_const", rx_data, 8'h00);
        xfer("t2", 8'h1E, 1'b1, 3, -1, 0);
        chk("t2_rx_const", rx_data, 8'h1E);
        xfer("t3", 8'hA5, 1'b0, 1, 4, 3);
        chk("t3_rx_const", rx_data, 8'hFF);

        // tx_valid held high: the second word must wait for tx_ready
        @(negedge clk);
        tx_data = 8'h01; dir = 1'b0; sin_drv = 1'b0; tx_valid = 1'b1;
        k = 0; cyc = 0;
        while (k < 2 && cyc < 40) begin
            #1;
            if (tx_ready) begin
                hs[k] = cyc;
                k++;
            end
            @(negedge clk);
            cyc++;
            if (k == 1 && cyc == hs[0] + 1) begin
                tx_data = 8'h80;
                #1 chk("b2b_load_par", sr_par, 8'h01);
                chk("b2b_busy", busy, 1);
            end
        end
        tx_valid = 1'b0;
        chk("b2b_count", k, 2);
        chk("b2b_gap", hs[1] - hs[0], 11);
        #1 chk("b2b_load2_par", sr_par, 8'h80);
        repeat (11) @(negedge clk);
        #1 chk("b2b_rx", rx_data, 8'h00);

        for (int r = 0; r < 6; r++) begin
            int pa, pl;
            pa = $urandom_range(1, 7);
            pl = $urandom_range(0, 4);
            xfer("rnd", 8'($urandom), 1'($urandom), 2, pa, pl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule

// File: doc/shift_seq.md
# shift_seq

Sequencer for the 8-bit multi-mode shift register (HOLD/LOAD/LEFT/RIGHT). It accepts one parallel word per valid/ready handshake and drives the register's mode, parallel and serial inputs to LOAD the word, then shift it WIDTH times. The bit leaving the register is presented on a serial output, and the bits entering from a serial input are captured. The result is a full-duplex serial transmit/receive engine, with pause support, built around the existing register.

## Interface
- WIDTH, 8, shift register width; also the number of shift cycles per transfer.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tx_valid_i  in  1  requester has a word on tx_data_i.
- tx_ready_o  out  1  block can accept a word (high only in IDLE).
- tx_data_i  in  WIDTH  word to transmit.
- dir_i  in  1  0 = LEFT (MSB first), 1 = RIGHT (LSB first); sampled at handshake.
- pause_i  in  1  stall shifting while high.
- sin_i  in  1  serial receive bit.
- sr_p_i  in  WIDTH  shift register parallel output P.
- sr_mode_o  out  2  to register mode_i: 00 HOLD, 01 LOAD, 10 LEFT, 11 RIGHT.
- sr_par_o  out  WIDTH  to register par_i.
- sr_d_o  out  1  to register D.
- sout_o  out  1  transmitted bit; meaningful only while sout_valid_o is high.
- sout_valid_o  out  1  a shift occurs at this clock edge.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse at the end of a transfer.
- rx_data_o  out  WIDTH  received word; updated when done_o is high.

## Operation
FSM states are IDLE, LOAD, SHIFT and DONE.

- **IDLE**
  - tx_ready_o=1; sr_mode_o=00.
  - On tx_valid_i && tx_ready_o: latch tx_data_i into data_q and dir_i into dir_q, then go to LOAD.
- **LOAD**
  - sr_mode_o=01; sr_par_o=data_q.
  - Go to SHIFT unconditionally; pause_i is ignored in this state.
- **SHIFT**
  - When pause_i=0:
    - sr_mode_o = dir_q ? 11 : 10.
    - sr_d_o = sin_i.
    - sout_o = dir_q ? sr_p_i[0] : sr_p_i[WIDTH-1].
    - sout_valid_o=1.
    - cnt increments.
  - When pause_i=1: sr_mode_o=00, sout_valid_o=0, cnt holds.
  - After the shift with cnt==WIDTH-1, go to DONE.
- **DONE**
  - sr_mode_o=00; done_o=1; rx_data_o <= sr_p_i.
  - Go to IDLE.
- **Counter and data path**
  - cnt is $clog2(WIDTH)+1 bits wide and clears on entry to LOAD.
  - sr_par_o = data_q in all states; sr_d_o = sin_i in all states. The register ignores them except in LOAD and SHIFT respectively.
  - rx_data_o holds its value between transfers.
  - In LEFT mode the first received bit ends in P[WIDTH-1]. In RIGHT mode it ends in P[0].
- **Reset**
  - Applies from any state; the next state is IDLE.
  - Register values after reset: data_q=0, dir_q=0, cnt=0, rx_data_o=0.
  - Combinational outputs in IDLE after reset: sr_mode_o=00, done_o=0, sout_valid_o=0, busy_o=0, tx_ready_o=1.
  - rst does not reset the shift register contents. Reset mid-transfer abandons the transfer without a done_o pulse.
- **tx_valid_i outside IDLE**
  - Ignored; the requester holds it until tx_ready_o is high.

## Timing
- Handshake at edge T. LOAD is driven during cycle T+1, so P = data at T+2.
- Without pause, SHIFT occupies cycles T+2..T+WIDTH+1, with one sout bit per cycle.
- DONE is cycle T+WIDTH+2; rx_data_o is valid from T+WIDTH+3.
- IDLE with tx_ready_o=1 is cycle T+WIDTH+3. The minimum spacing between handshakes is WIDTH+3 cycles (11 for WIDTH=8).
- Each paused SHIFT cycle adds exactly one cycle of latency.
- All outputs except the registered rx_data_o are combinational functions of state, the latched fields, sr_p_i, sin_i and pause_i. There is no path from tx_valid_i to sr_mode_o in the same cycle.

## Test plan
- Send 0x1E with dir=0 and sin_i=0. Required: sout bits 0,0,0,1,1,1,1,0 on 8 consecutive sout_valid_o cycles, done_o 10 cycles after the handshake, rx_data_o=0x00.
- Send 0x1E with dir=1 and sin_i tied to sout_o (loopback). Required: sout bits 0,1,1,1,1,0,0,0, rx_data_o=0x1E, and P=0x1E after done.
- Send 0xA5 with dir=0 and sin_i=1, with pause_i high for 3 cycles after the 4th shift. Required: sr_mode_o=00 and sout_valid_o=0 during the pause, the bit stream is unchanged, done_o is 3 cycles late, rx_data_o=0xFF.
- Hold tx_valid_i high continuously with words 0x01 then 0x80. Required: handshakes exactly 11 cycles apart, and the second word is ignored until tx_ready_o rises.
- Assert rst for 1 cycle during the 5th shift. Required: IDLE on the next cycle with sr_mode_o=00, busy_o=0, tx_ready_o=1, no done_o pulse, and rx_data_o unchanged from reset (0x00).
